// File: rtl/sklansky_addsub_pipe.sv
// Pipelined Sklansky parallel-prefix adder/subtractor with an |a-b| mode.
// Three register stages (operand g/p, prefix carries, result) share one
// advance enable, so the whole pipe either shifts or holds as a unit.
module sklansky_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter bit ABS_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Prefix trees run over WIDTH+1 nodes: the carry-in occupies node 0 (bit -1).
  localparam int LV = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ABS  = 2'b10;
  localparam logic [1:0] OP_ADDC = 2'b11;

  logic       adv;
  logic [3:1] vld_pipe;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[3];

  // ---------------- S1: bitwise generate/propagate ----------------
  logic             inv_b;
  logic [WIDTH-1:0] bx;
  logic             c0;

  // Select b or ~b and the prefix carry-in for the requested operation.
  always_comb begin
    inv_b = (op == OP_SUB) || (op == OP_ABS);
    bx    = inv_b ? ~b : b;
    c0    = inv_b | ((op == OP_ADDC) & cin);
    if (op == OP_ADD) c0 = 1'b0;
  end

  logic [WIDTH-1:0] g1, p1;
  logic             c0_1;
  logic [1:0]       op1;

  // Stage-1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      g1          <= '0;
      p1          <= '0;
      c0_1        <= 1'b0;
      op1         <= OP_ADD;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      g1          <= a & bx;
      p1          <= a ^ bx;
      c0_1        <= c0;
      op1         <= op;
    end
  end

  // ---------------- S2: Sklansky carry prefix tree ----------------
  logic [LV:0][WIDTH:0] gt, pt;

  // Level l merges each node with bit l set into the top node of the block
  // just below it. Once a span reaches node 0 its propagate is irrelevant
  // (gray cell), so it is tied to 0.
  always_comb begin
    int k;
    k     = 0;
    gt    = '0;
    pt    = '0;
    gt[0] = {g1, c0_1};
    pt[0] = {p1, 1'b0};
    for (int l = 0; l < LV; l++) begin
      for (int j = 0; j <= WIDTH; j++) begin
        if (((j >> l) & 1) == 1) begin
          k              = ((j >> l) << l) - 1;
          gt[l+1][j]     = gt[l][j] | (pt[l][j] & gt[l][k]);
          pt[l+1][j]     = (((j >> (l + 1)) << (l + 1)) == 0) ? 1'b0
                                                              : (pt[l][j] & pt[l][k]);
        end else begin
          gt[l+1][j]     = gt[l][j];
          pt[l+1][j]     = pt[l][j];
        end
      end
    end
  end

  // cg2[i] = G[i-1:-1], i.e. the carry into bit i; cg2[WIDTH] is the carry out.
  logic [WIDTH:0]   cg2;
  logic [WIDTH-1:0] p2;
  logic [1:0]       op2;

  // Stage-2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[2] <= 1'b0;
      cg2         <= '0;
      p2          <= '0;
      op2         <= OP_ADD;
    end else if (adv) begin
      vld_pipe[2] <= vld_pipe[1];
      cg2         <= gt[LV];
      p2          <= p1;
      op2         <= op1;
    end
  end

  // ---------------- S3: sum, flags, conditional negate ----------------
  logic [WIDTH-1:0] raw, nraw, neg;
  logic             cfin, ovf_raw, is_abs;
  logic [LV:0][WIDTH:0] at;

  // Result bits, and for a<b in ABSDIFF the two's-complement negate built as
  // an incrementer of ~raw whose carries are an AND-prefix over ~raw.
  always_comb begin
    int k;
    k       = 0;
    raw     = p2 ^ cg2[WIDTH-1:0];
    cfin    = cg2[WIDTH];
    ovf_raw = cg2[WIDTH] ^ cg2[WIDTH-1];
    is_abs  = ABS_EN && (op2 == OP_ABS);
    nraw    = ~raw;
    at      = '0;
    at[0]   = {nraw, 1'b1};
    for (int l = 0; l < LV; l++) begin
      for (int j = 0; j <= WIDTH; j++) begin
        if (((j >> l) & 1) == 1) begin
          k          = ((j >> l) << l) - 1;
          at[l+1][j] = at[l][j] & at[l][k];
        end else begin
          at[l+1][j] = at[l][j];
        end
      end
    end
    neg = nraw ^ at[LV][WIDTH-1:0];
  end

  // Output registers; they hold while a result waits for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[3] <= 1'b0;
      sum         <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
    end else if (adv) begin
      vld_pipe[3] <= vld_pipe[2];
      sum         <= (is_abs && !cfin) ? neg : raw;
      cout        <= cfin;
      ovf         <= is_abs ? 1'b0 : ovf_raw;
    end
  end

endmodule

// File: tb/tb_sklansky_addsub_pipe.sv
// Scoreboard bench for sklansky_addsub_pipe at a non-power-of-two width.
module tb_sklansky_addsub_pipe;
  localparam int W = 13;
  localparam logic [W-1:0] MAXV = '1;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, cout, ovf;
  logic [1:0]   op;

  int checks = 0;
  int failures = 0;
  logic rdy_rand = 1'b0;

  logic [W+1:0] q[$];   // {sum, cout, ovf}

  sklansky_addsub_pipe #(.WIDTH(W), .ABS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, mb,
                                         input logic mc, input logic [1:0] mop);
    logic [W:0]   f;
    logic [W-1:0] s;
    logic         co, ov;
    f = '0; s = '0; co = 1'b0; ov = 1'b0;
    case (mop)
      2'd0, 2'd3: begin
        f  = {1'b0, ma} + {1'b0, mb} + ((mop == 2'd3 && mc) ? 1 : 0);
        s  = f[W-1:0];
        co = f[W];
        ov = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
      end
      2'd1: begin
        s  = ma - mb;
        co = (ma >= mb);
        ov = (ma[W-1] != mb[W-1]) && (s[W-1] != ma[W-1]);
      end
      default: begin
        co = (ma >= mb);
        s  = co ? (ma - mb) : (mb - ma);
        ov = 1'b0;
      end
    endcase
    return {s, co, ov};
  endfunction

  // Drive one beat; push the expectation at the accepting edge.
  task automatic send(input logic [W-1:0] ta, tb, input logic tc, input logic [1:0] to,
                      input bit use_exp, input logic [W+1:0] exp);
    int n;
    n = 0;
    a = ta; b = tb; cin = tc; op = to; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(use_exp ? exp : model(ta, tb, tc, to));
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 1000) begin
        checks++; failures++;
        $display("FAIL accept_timeout in_ready stuck at %0b, required 1", in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required 0", q.size());
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = (($urandom % 4) != 0);
  end

  // Monitor: compare consumed results, check stall behaviour.
  logic         held = 1'b0;
  logic [W+1:0] held_val;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready actual=%b required=0", in_ready);
        end
        if (held) begin
          checks++;
          if ({sum, cout, ovf} !== held_val) begin
            failures++;
            $display("FAIL stall_hold actual=%h required=%h", {sum, cout, ovf}, held_val);
          end
        end
        held = 1'b1;
        held_val = {sum, cout, ovf};
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        logic [W+1:0] e;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output actual=%h required none", {sum, cout, ovf});
        end else begin
          e = q.pop_front();
          if ({sum, cout, ovf} !== e) begin
            failures++;
            $display("FAIL result sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, e[W+1:2], e[1], e[0]);
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {{(W+1){1'b0}}, out_valid}, '0);
    chk("reset_outputs", {sum, cout, ovf}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});
    @(posedge clk); #1;

    // Latency from an idle pipe: signed overflow case.
    send(13'h0FFF, 13'h0001, 1'b0, 2'd0, 1'b1, {13'h1000, 1'b0, 1'b1});
    n = 0;
    while (n < 10) begin
      @(negedge clk); n++;
      if (out_valid) break;
    end
    chk("latency", n, 3);
    @(posedge clk); #1;
    drain();

    // Directed boundary vectors with hand-derived results.
    send(13'h0005, 13'h0007, 1'b0, 2'd1, 1'b1, {13'h1FFE, 1'b0, 1'b0});
    send(13'h0005, 13'h0007, 1'b0, 2'd2, 1'b1, {13'h0002, 1'b0, 1'b0});
    send(MAXV,     13'h0000, 1'b1, 2'd3, 1'b1, {13'h0000, 1'b1, 1'b0});
    send(13'h0000, MAXV,     1'b0, 2'd2, 1'b1, {13'h1FFF, 1'b0, 1'b0});
    send(13'h00AB, 13'h00AB, 1'b0, 2'd2, 1'b1, {13'h0000, 1'b1, 1'b0});
    send(MAXV,     13'h0001, 1'b0, 2'd0, 1'b1, {13'h0000, 1'b1, 1'b0});
    send(13'h0000, 13'h0001, 1'b0, 2'd1, 1'b1, {13'h1FFF, 1'b0, 1'b0});
    send(13'h0FFF, 13'h0001, 1'b1, 2'd0, 1'b1, {13'h1000, 1'b0, 1'b1});
    send(13'h1000, 13'h0001, 1'b0, 2'd1, 1'b1, {13'h0FFF, 1'b1, 1'b1});
    drain();

    // Ten back-to-back beats with a 5-cycle output stall.
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom), 1'b0, '0);
      end
      begin
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++)
      send(W'($urandom), W'($urandom), 1'b0, 2'd0, 1'b0, '0);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_no_valid", {{(W+1){1'b0}}, out_valid}, '0);
    end
    @(posedge clk); #1;

    // Random operations under random backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      case ($urandom % 4)
        0: ra = MAXV;
        1: ra = '0;
        default: ra = W'($urandom);
      endcase
      rb = ((($urandom % 8) == 0) ? ra : W'($urandom));
      send(ra, rb, 1'($urandom), 2'($urandom), 1'b0, '0);
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout reached, required completion");
    $fatal(1, "timeout");
  end
endmodule
